// File: rtl/cim_pkg.sv
// Shared elaboration helpers for the CIM shift-accumulate tree: ceiling log2
// and the accumulator width derivation.
package cim_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Tree growth (clog2 of the column count) plus the bit-plane shift range.
  function automatic int acc_width(input int n_in, input int in_w, input int n_bits);
    return in_w + clog2(n_in) + n_bits;
  endfunction

endpackage

// File: rtl/cim_pipe_adder_tree.sv
// Pipelined binary adder tree: N_IN unsigned columns reduced in clog2(N_IN)
// registered levels, with a valid bit and opaque tag carried alongside.
module cim_pipe_adder_tree
  import cim_pkg::*;
#(
  parameter int N_IN  = 32,
  parameter int IN_W  = 4,
  parameter int TAG_W = 1,
  localparam int L     = clog2(N_IN),
  localparam int SUM_W = IN_W + L
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [N_IN*IN_W-1:0] in_data,
  output logic                 out_valid,
  output logic [TAG_W-1:0]     out_tag,
  output logic [SUM_W-1:0]     out_sum
);

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int W = N_IN >> l;
    logic [SUM_W-1:0] sum [W];
    logic             v;
    logic [TAG_W-1:0] tag;

    if (l == 0) begin : g_in
      assign v   = in_valid;
      assign tag = in_tag;
      for (genvar i = 0; i < W; i++) begin : g_col
        assign sum[i] = SUM_W'(in_data[i*IN_W +: IN_W]);
      end
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v   <= 1'b0;
          tag <= '0;
        end else begin
          v   <= g_lvl[l-1].v;
          tag <= g_lvl[l-1].tag;
        end
      end

      // NOTE: partial sums carry no reset; the valid bit alone qualifies them.
      for (genvar i = 0; i < W; i++) begin : g_add
        always_ff @(posedge clk) begin
          sum[i] <= g_lvl[l-1].sum[2*i] + g_lvl[l-1].sum[2*i+1];
        end
      end
    end
  end

  assign out_valid = g_lvl[L].v;
  assign out_tag   = g_lvl[L].tag;
  assign out_sum   = g_lvl[L].sum[0];

endmodule

// File: rtl/cim_shift_acc_tree.sv
// Bit-serial CIM accumulator: each activation plane is summed across columns,
// weighted by its bit position (MSB negative in signed frames) and accumulated.
module cim_shift_acc_tree
  import cim_pkg::*;
#(
  parameter int N_IN   = 32,
  parameter int IN_W   = 4,
  parameter int N_BITS = 4,
  localparam int L     = clog2(N_IN),
  localparam int ACC_W = acc_width(N_IN, IN_W, N_BITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic                 signed_mode,
  input  logic [N_IN*IN_W-1:0] in_data,
  output logic                 out_valid,
  output logic [ACC_W-1:0]     out_data,
  output logic                 err
);

  localparam int IDX_W = (N_BITS > 1) ? clog2(N_BITS) : 1;
  localparam int SUM_W = IN_W + L;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             load;   // first plane: accumulator restarts
    logic             close;  // plane ends the frame
    logic             keep;   // plane belongs to a frame
    logic             neg;    // MSB plane of a signed frame
    logic             err;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  logic [IDX_W-1:0] idx_q;
  logic             signed_q;
  logic             open_q;

  logic [IDX_W-1:0] idx_c;
  logic             signed_c;
  logic             accept_c;
  logic             last_idx_c;
  logic             close_c;
  tag_t             tag_c;

  // NOTE: every always_comb output is assigned a default first so no latch forms.
  always_comb begin
    idx_c      = in_first ? '0 : idx_q + 1'b1;
    signed_c   = in_first ? signed_mode : signed_q;
    accept_c   = in_first | open_q;
    last_idx_c = (idx_c == IDX_W'(N_BITS - 1));
    close_c    = in_last | last_idx_c;

    tag_c       = '0;
    tag_c.idx   = idx_c;
    tag_c.load  = in_first;
    tag_c.close = accept_c & close_c;
    tag_c.keep  = accept_c;
    tag_c.neg   = signed_c & last_idx_c;
    // Stray plane, aborted frame, short frame, or MSB plane without in_last.
    tag_c.err   = ~accept_c | (in_first & open_q) | (accept_c & (in_last != last_idx_c));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q    <= '0;
      signed_q <= 1'b0;
      open_q   <= 1'b0;
    end else if (in_valid && accept_c) begin
      idx_q    <= idx_c;
      signed_q <= signed_c;
      open_q   <= ~close_c;
    end
  end

  logic             tree_valid;
  logic [TAG_W-1:0] tree_tag;
  logic [SUM_W-1:0] tree_sum;
  tag_t             t_out;

  cim_pipe_adder_tree #(
    .N_IN (N_IN),
    .IN_W (IN_W),
    .TAG_W(TAG_W)
  ) u_tree (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_tag   (tag_c),
    .in_data  (in_data),
    .out_valid(tree_valid),
    .out_tag  (tree_tag),
    .out_sum  (tree_sum)
  );

  assign t_out = tag_t'(tree_tag);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] shifted;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] total;

  always_comb begin
    shifted = ACC_W'(tree_sum) << t_out.idx;
    term    = t_out.neg ? -shifted : shifted;
    total   = (t_out.load ? '0 : acc_q) + term;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= tree_valid & t_out.close;
      err       <= tree_valid & t_out.err;
      if (tree_valid && t_out.keep) begin
        acc_q <= total;
        if (t_out.close) out_data <= total;
      end
    end
  end

endmodule

// File: tb/tb_cim_shift_acc_tree.sv
// Directed bench for cim_shift_acc_tree at default parameters (L=5, ACC_W=13);
// expected results are hand-computed constants.
module tb_cim_shift_acc_tree;

  localparam int N_IN  = 32;
  localparam int IN_W  = 4;
  localparam int ACC_W = 13;
  localparam int LAT   = 6;
  localparam int MAX_EV = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_first;
  logic                 in_last;
  logic                 signed_mode;
  logic [N_IN*IN_W-1:0] in_data;
  logic                 out_valid;
  logic [ACC_W-1:0]     out_data;
  logic                 err;

  cim_shift_acc_tree dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_first   (in_first),
    .in_last    (in_last),
    .signed_mode(signed_mode),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Output event log, sampled on the falling edge.
  int          n_ev = 0;
  int          ev_cyc  [MAX_EV];
  logic        ev_ov   [MAX_EV];
  logic        ev_err  [MAX_EV];
  logic [31:0] ev_data [MAX_EV];

  always @(negedge clk) begin
    if (out_valid || err) begin
      if (n_ev < MAX_EV) begin
        ev_cyc[n_ev]  = cyc;
        ev_ov[n_ev]   = out_valid;
        ev_err[n_ev]  = err;
        ev_data[n_ev] = 32'(out_data);
      end
      n_ev++;
    end
  end

  task automatic clear_events();
    n_ev = 0;
    for (int i = 0; i < MAX_EV; i++) begin
      ev_cyc[i]  = -1;
      ev_ov[i]   = 1'b0;
      ev_err[i]  = 1'b0;
      ev_data[i] = '0;
    end
  endtask

  task automatic check_ev(input string name, input int i, input int exp_cyc,
                          input logic exp_ov, input logic exp_err, input logic [31:0] exp_data);
    check({name, ".cycle"}, 32'(ev_cyc[i]), 32'(exp_cyc));
    check({name, ".out_valid"}, 32'(ev_ov[i]), 32'(exp_ov));
    check({name, ".err"}, 32'(ev_err[i]), 32'(exp_err));
    if (exp_ov) check({name, ".out_data"}, ev_data[i], exp_data);
  endtask

  int t_last;

  task automatic set_plane(input logic first, input logic last, input logic sm,
                           input logic [IN_W-1:0] val);
    in_valid    = 1'b1;
    in_first    = first;
    in_last     = last;
    signed_mode = sm;
    for (int k = 0; k < N_IN; k++) in_data[k*IN_W +: IN_W] = val;
    t_last = cyc;
  endtask

  task automatic plane(input logic first, input logic last, input logic sm,
                       input logic [IN_W-1:0] val);
    @(negedge clk);
    set_plane(first, last, sm, val);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic frame(input logic [IN_W-1:0] val, input logic sm);
    plane(1'b1, 1'b0, sm, val);
    plane(1'b0, 1'b0, sm, val);
    plane(1'b0, 1'b0, sm, val);
    plane(1'b0, 1'b1, sm, val);
  endtask

  int t_a;
  int t_b;

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_first    = 1'b0;
    in_last     = 1'b0;
    signed_mode = 1'b0;
    in_data     = '0;
    clear_events();
    repeat (3) @(negedge clk);

    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.err", 32'(err), 32'd0);
    check("reset.out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    // Unsigned full frame, all columns 15: 480 * 15 = 7200.
    clear_events();
    frame(4'd15, 1'b0);
    idle(12);
    check("basic.events", 32'(n_ev), 32'd1);
    check_ev("basic", 0, t_last + LAT, 1'b1, 1'b0, 32'd7200);

    // Signed frame, all columns 1: 32 * (1 + 2 + 4 - 8) = -32.
    clear_events();
    frame(4'd1, 1'b1);
    idle(12);
    check("signed.events", 32'(n_ev), 32'd1);
    check_ev("signed", 0, t_last + LAT, 1'b1, 1'b0, 32'h1FE0);

    // Back-to-back frames without a bubble.
    clear_events();
    frame(4'd1, 1'b0);
    t_a = t_last;
    frame(4'd2, 1'b0);
    idle(12);
    check("b2b.events", 32'(n_ev), 32'd2);
    check_ev("b2b0", 0, t_a + LAT, 1'b1, 1'b0, 32'd480);
    check_ev("b2b1", 1, t_a + LAT + 4, 1'b1, 1'b0, 32'd960);

    // Two-cycle bubbles between planes.
    clear_events();
    plane(1'b1, 1'b0, 1'b0, 4'd15);
    idle(2);
    plane(1'b0, 1'b0, 1'b0, 4'd15);
    idle(2);
    plane(1'b0, 1'b0, 1'b0, 4'd15);
    idle(2);
    plane(1'b0, 1'b1, 1'b0, 4'd15);
    idle(12);
    check("bubble.events", 32'(n_ev), 32'd1);
    check_ev("bubble", 0, t_last + LAT, 1'b1, 1'b0, 32'd7200);

    // Abort: in_first on the third plane of an open frame, then a full frame of 1s.
    clear_events();
    plane(1'b1, 1'b0, 1'b0, 4'd7);
    plane(1'b0, 1'b0, 1'b0, 4'd7);
    plane(1'b1, 1'b0, 1'b0, 4'd1);
    t_b = t_last;
    plane(1'b0, 1'b0, 1'b0, 4'd1);
    plane(1'b0, 1'b0, 1'b0, 4'd1);
    plane(1'b0, 1'b1, 1'b0, 4'd1);
    idle(12);
    check("abort.events", 32'(n_ev), 32'd2);
    check_ev("abort.err", 0, t_b + LAT, 1'b0, 1'b1, 32'd0);
    check_ev("abort.res", 1, t_last + LAT, 1'b1, 1'b0, 32'd480);

    // Short frame: in_first and in_last together, partial result 480 with err.
    clear_events();
    plane(1'b1, 1'b1, 1'b0, 4'd15);
    idle(12);
    check("short.events", 32'(n_ev), 32'd1);
    check_ev("short", 0, t_last + LAT, 1'b1, 1'b1, 32'd480);

    // MSB plane without in_last closes with err; a following stray plane is dropped.
    clear_events();
    frame(4'd1, 1'b0);
    plane(1'b1, 1'b0, 1'b0, 4'd1);
    plane(1'b0, 1'b0, 1'b0, 4'd1);
    plane(1'b0, 1'b0, 1'b0, 4'd1);
    plane(1'b0, 1'b0, 1'b0, 4'd1);
    t_a = t_last;
    plane(1'b0, 1'b0, 1'b0, 4'd3);
    t_b = t_last;
    idle(12);
    check("force.events", 32'(n_ev), 32'd3);
    check_ev("force.ok", 0, t_a + LAT - 4, 1'b1, 1'b0, 32'd480);
    check_ev("force.close", 1, t_a + LAT, 1'b1, 1'b1, 32'd480);
    check_ev("force.drop", 2, t_b + LAT, 1'b0, 1'b1, 32'd0);
    check("hold.out_data", 32'(out_data), 32'd480);

    // Reset mid-frame: in-flight planes vanish, the next cycle accepts a plane.
    clear_events();
    plane(1'b1, 1'b0, 1'b0, 4'd5);
    plane(1'b0, 1'b0, 1'b0, 4'd5);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("rst.out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    set_plane(1'b1, 1'b0, 1'b0, 4'd15);
    plane(1'b0, 1'b0, 1'b0, 4'd15);
    plane(1'b0, 1'b0, 1'b0, 4'd15);
    plane(1'b0, 1'b1, 1'b0, 4'd15);
    idle(12);
    check("rst.events", 32'(n_ev), 32'd1);
    check_ev("rst", 0, t_last + LAT, 1'b1, 1'b0, 32'd7200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cim_shift_acc_tree.md
CIM_SHIFT_ACC_TREE -- requirements
Module: cim_shift_acc_tree

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  N_IN, 32, number of CIM column inputs summed per plane (power of two, >=2)
  IN_W, 4, width of each unsigned column input
  N_BITS, 4, activation bit-planes per frame (>=1)
REQ-002 The block SHALL derive L = clog2(N_IN) and ACC_W = IN_W + L + N_BITS.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  single clock, all logic on rising edge
  rst_n  in  1  reset, synchronous, active-low
  in_valid  in  1  plane present this cycle
  in_first  in  1  plane is bit 0 (LSB) of a new frame
  in_last  in  1  plane closes the frame
  signed_mode  in  1  frame activation is two's complement; sampled with in_first
  in_data  in  N_IN*IN_W  column values, column k at bits [k*IN_W +: IN_W]
  out_valid  out  1  one-cycle pulse, out_data holds a frame result
  out_data  out  ACC_W  shift-accumulated result (signed if frame signed_mode=1)
  err  out  1  one-cycle pulse, aligned with out_valid or an abort

Function
REQ-004 The block SHALL sample a plane only when in_valid=1; cycles with in_valid=0 SHALL be bubbles with no state change except pipeline advance.
REQ-005 No backpressure: the block SHALL accept one plane every cycle indefinitely.
REQ-006 The plane index SHALL be 0 on a plane with in_first=1, else previous index+1; it SHALL travel with the plane through the pipeline.
REQ-007 The adder tree SHALL sum all N_IN columns (unsigned, zero-extended, no overflow) in L register levels, one adder level per stage.
REQ-008 Each plane term SHALL be sum << index; when the frame's signed_mode=1 and index = N_BITS-1, the term SHALL be negated (MSB weight -2^(N_BITS-1)).
REQ-009 The accumulator SHALL load the term on a first plane and add the term otherwise, in ACC_W bits, two's complement.
REQ-010 On the last plane, out_data SHALL register accumulator+term and out_valid SHALL be 1 for exactly the cycle T+L+1, T = cycle the last plane was sampled.
REQ-011 A plane with index N_BITS-1 SHALL close the frame even if in_last=0; err SHALL pulse with that out_valid.
REQ-012 in_last on index < N_BITS-1 (short frame, incl. in_first with in_last) SHALL produce out_valid with the partial result and err=1.
REQ-013 in_first while a frame is open SHALL discard the partial frame, emit err=1 without out_valid at the abort plane's T+L+1, and start the new frame.
REQ-014 A plane arriving with no open frame and in_first=0 SHALL be dropped and pulse err at T+L+1.
REQ-015 out_data SHALL hold its value between out_valid pulses.
REQ-016 Back-to-back frames with no bubble SHALL yield out_valid pulses exactly N_BITS cycles apart.

Reset
REQ-017 rst_n=0 at a rising edge SHALL clear all pipeline valid bits, plane index, frame-open flag, accumulator, out_valid, err and out_data to 0.
REQ-018 Planes in flight at reset SHALL be discarded; no out_valid or err SHALL result from them.
REQ-019 The first cycle after rst_n returns high SHALL accept a plane.

Structure
REQ-020 Package cim_pkg SHALL hold a clog2 function and the ACC_W derivation; no other typedefs.
REQ-021 The pipelined tree SHALL be one sub-module, cim_pipe_adder_tree (parameters N_IN, IN_W), carrying a valid/tag sideband of configurable width with latency L.
REQ-022 Index counting, signed weighting, accumulation and error logic SHALL reside in cim_shift_acc_tree.

Verification (defaults, L=5, ACC_W=13)
REQ-023 Unsigned, all columns 15, 4 planes with in_first/in_last marked -> out_data 7200, err 0, out_valid at T+6.
REQ-024 signed_mode=1, all columns 1 on all 4 planes -> out_data -32 (13'h1FE0), err 0.
REQ-025 Two unsigned frames back-to-back, all columns 1 then all columns 2 -> results 480 and 960, out_valid pulses 4 cycles apart.
REQ-026 Frame of REQ-023 with 2-cycle bubbles between planes -> 7200, out_valid 6 cycles after last plane.
REQ-027 in_first on plane 2 of an open frame, then full frame of all 1 -> err pulse alone, then 480 with err 0.
REQ-028 rst_n low for 1 cycle after plane 2 of a frame -> no out_valid, no err; following full frame of all 15 -> 7200.
